// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle base ops, XLEN-cycle shift-add multiply and, when
// ALU_ITER_DIV_EN is defined, an XLEN-cycle restoring divider.
module alu_iter #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            branch_op,
    input  logic [5:0]      ALU_Control,
    input  logic [XLEN-1:0] operand_A,
    input  logic [XLEN-1:0] operand_B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_result,
    output logic            branch,
    output logic            busy
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b001000;
    localparam logic [5:0] OP_SLT   = 6'b000010;
    localparam logic [5:0] OP_SLTU  = 6'b000011;
    localparam logic [5:0] OP_BLTU  = 6'b010110;
    localparam logic [5:0] OP_BGE   = 6'b010101;
    localparam logic [5:0] OP_BGEU  = 6'b010111;
    localparam logic [5:0] OP_OR    = 6'b000110;
    localparam logic [5:0] OP_XOR   = 6'b000100;
    localparam logic [5:0] OP_AND   = 6'b000111;
    localparam logic [5:0] OP_SLL   = 6'b000001;
    localparam logic [5:0] OP_SRL   = 6'b000101;
    localparam logic [5:0] OP_SRA   = 6'b001101;
    localparam logic [5:0] OP_EQ    = 6'b010000;
    localparam logic [5:0] OP_NE    = 6'b010001;
    localparam logic [5:0] OP_PASSA = 6'b011111;
    localparam logic [5:0] OP_PASSB = 6'b111111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg, state_next;

    logic              accept;
    logic              start_iter;
    logic              last_iter;
    logic              is_mul_in;
    logic              is_div_in;
    logic [SHW-1:0]    shamt;

    logic [XLEN-1:0]   base_result;
    logic              base_branch;
    logic              cmp_op;
    logic              cmp_hit;
    logic              cmp_true;

    logic              sign_a;
    logic              sign_b;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;

    // hi/lo hold {product high, multiplier} for multiply and {remainder, quotient} for divide
    logic [XLEN-1:0]   hi_reg, lo_reg, md_reg;
    logic [XLEN-1:0]   hi_next, lo_next;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   iter_final;
    logic [1:0]        mode_reg;
    logic              neg_q_reg;
    logic [SHW-1:0]    cnt_reg;
    logic [XLEN-1:0]   result_reg;
    logic              branch_reg;

`ifdef ALU_ITER_DIV_EN
    logic              div_reg;
    logic              neg_r_reg;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   div_special;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
`endif

    assign is_mul_in = (ALU_Control[5:2] == 4'b1000);
    assign is_div_in = (ALU_Control[5:2] == 4'b1001);
    assign shamt     = operand_B[SHW-1:0];
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt_reg == SHW'(XLEN - 1));

`ifdef ALU_ITER_DIV_EN
    // Divide by zero and signed overflow have closed-form answers, so they bypass BUSY
    always_comb begin
        div_zero = (operand_B == '0);
        div_ovf  = !ALU_Control[0] && (operand_A == {1'b1, {(XLEN-1){1'b0}}})
                   && (operand_B == '1);
        if (ALU_Control[1]) begin
            div_special = div_zero ? operand_A : '0;
        end else begin
            div_special = div_zero ? '1 : operand_A;
        end
    end

    assign start_iter = is_mul_in || (is_div_in && !div_zero && !div_ovf);
`else
    assign start_iter = is_mul_in;
`endif

    always_comb begin
        base_result = '0;
        cmp_op      = 1'b0;
        cmp_hit     = 1'b0;
        cmp_true    = 1'b0;
        case (ALU_Control)
            OP_ADD:   base_result = operand_A + operand_B;
            OP_SUB:   base_result = operand_A - operand_B;
            OP_SLT:   begin cmp_op = 1'b1; cmp_hit = 1'b1; cmp_true = $signed(operand_A) < $signed(operand_B); end
            OP_SLTU:  begin cmp_op = 1'b1; cmp_true = operand_A < operand_B; end
            OP_BLTU:  begin cmp_op = 1'b1; cmp_hit = 1'b1; cmp_true = operand_A < operand_B; end
            OP_BGE:   begin cmp_op = 1'b1; cmp_hit = 1'b1; cmp_true = $signed(operand_A) >= $signed(operand_B); end
            OP_BGEU:  begin cmp_op = 1'b1; cmp_hit = 1'b1; cmp_true = operand_A >= operand_B; end
            OP_EQ:    begin cmp_op = 1'b1; cmp_hit = 1'b1; cmp_true = operand_A == operand_B; end
            OP_NE:    begin cmp_op = 1'b1; cmp_hit = 1'b1; cmp_true = operand_A != operand_B; end
            OP_OR:    base_result = operand_A | operand_B;
            OP_XOR:   base_result = operand_A ^ operand_B;
            OP_AND:   base_result = operand_A & operand_B;
            OP_SLL:   base_result = operand_A << shamt;
            OP_SRL:   base_result = operand_A >> shamt;
            OP_SRA:   base_result = $signed(operand_A) >>> shamt;
            OP_PASSA: base_result = operand_A;
            OP_PASSB: base_result = operand_A;
            default:  base_result = '0;
        endcase
        if (cmp_op) begin
            base_result = XLEN'(cmp_true);
        end
        base_branch = branch_op && cmp_hit && cmp_true;
    end

    // Iterative units work on magnitudes; the sign is restored on the final step
    always_comb begin
        sign_a = (ALU_Control[1:0] != 2'b11);
        sign_b = !ALU_Control[1];
`ifdef ALU_ITER_DIV_EN
        if (is_div_in) begin
            sign_a = !ALU_Control[0];
            sign_b = !ALU_Control[0];
        end
`endif
        a_neg = sign_a && operand_A[XLEN-1];
        b_neg = sign_b && operand_B[XLEN-1];
        a_abs = a_neg ? -operand_A : operand_A;
        b_abs = b_neg ? -operand_B : operand_B;
    end

    always_comb begin
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, md_reg} : '0);
        hi_next = mul_sum[XLEN:1];
        lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
`ifdef ALU_ITER_DIV_EN
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, md_reg});
        div_diff  = div_shift[XLEN-1:0] - md_reg;
        if (div_reg) begin
            hi_next = div_ge ? div_diff : div_shift[XLEN-1:0];
            lo_next = {lo_reg[XLEN-2:0], div_ge};
        end
`endif
    end

    always_comb begin
        prod        = {hi_next, lo_next};
        prod_signed = neg_q_reg ? -prod : prod;
        iter_final  = (mode_reg == 2'b00) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
`ifdef ALU_ITER_DIV_EN
        if (div_reg) begin
            if (mode_reg[1]) begin
                iter_final = neg_r_reg ? -hi_next : hi_next;
            end else begin
                iter_final = neg_q_reg ? -lo_next : lo_next;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = start_iter ? BUSY : DONE;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        in_ready  = (state_reg == IDLE) && !flush;
        out_valid = (state_reg == DONE);
        busy      = (state_reg == BUSY);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_reg     <= '0;
            lo_reg     <= '0;
            md_reg     <= '0;
            mode_reg   <= '0;
            neg_q_reg  <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
            branch_reg <= 1'b0;
`ifdef ALU_ITER_DIV_EN
            div_reg    <= 1'b0;
            neg_r_reg  <= 1'b0;
`endif
        end else if (accept) begin
            mode_reg   <= ALU_Control[1:0];
            cnt_reg    <= '0;
            branch_reg <= 1'b0;
`ifdef ALU_ITER_DIV_EN
            div_reg    <= is_div_in;
            neg_r_reg  <= a_neg;
`endif
            if (is_mul_in) begin
                hi_reg    <= '0;
                lo_reg    <= b_abs;
                md_reg    <= a_abs;
                neg_q_reg <= a_neg ^ b_neg;
            end else if (is_div_in) begin
`ifdef ALU_ITER_DIV_EN
                if (start_iter) begin
                    hi_reg    <= '0;
                    lo_reg    <= a_abs;
                    md_reg    <= b_abs;
                    neg_q_reg <= a_neg ^ b_neg;
                end else begin
                    result_reg <= div_special;
                end
`else
                result_reg <= '1;
`endif
            end else begin
                result_reg <= base_result;
                branch_reg <= base_branch;
            end
        end else if (state_reg == BUSY && !flush) begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg + SHW'(1);
            if (last_iter) begin
                result_reg <= iter_final;
            end
        end
    end

    assign ALU_result = result_reg;
    assign branch     = branch_reg;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter (XLEN=32); divide expectations follow ALU_ITER_DIV_EN.
module tb_alu_iter;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b001000, SLT = 6'b000010, SLTU = 6'b000011;
    localparam logic [5:0] BLTU = 6'b010110, BGE = 6'b010101, BGEU = 6'b010111, OR_ = 6'b000110;
    localparam logic [5:0] XOR_ = 6'b000100, AND_ = 6'b000111, SLL = 6'b000001, SRL = 6'b000101;
    localparam logic [5:0] SRA = 6'b001101, EQ = 6'b010000, NE = 6'b010001, PASSA = 6'b011111;
    localparam logic [5:0] PASSB = 6'b111111, UNL = 6'b001111;
    localparam logic [5:0] MUL = 6'b100000, MULH = 6'b100001, MULHSU = 6'b100010, MULHU = 6'b100011;
    localparam logic [5:0] DIV = 6'b100100, DIVU = 6'b100101, REM = 6'b100110, REMU = 6'b100111;

    logic        clock, reset_n, flush, in_valid, in_ready, branch_op;
    logic        out_valid, out_ready, branch, busy;
    logic [5:0]  ALU_Control;
    logic [31:0] operand_A, operand_B, ALU_result;

    typedef struct {
        logic [31:0] res;
        logic        br;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    alu_iter #(.XLEN(32)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .branch_op(branch_op), .ALU_Control(ALU_Control),
        .operand_A(operand_A), .operand_B(operand_B), .out_valid(out_valid),
        .out_ready(out_ready), .ALU_result(ALU_result), .branch(branch), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [5:0] c, input logic [31:0] a,
                                   input logic [31:0] b, input logic bop);
        exp_t        e;
        logic [63:0] p;
        logic [63:0] t;
        logic        cmp;
        logic        cond;
        e.res = '0; e.br = 1'b0; e.lat = 1; cmp = 1'b0; cond = 1'b0; p = '0; t = '0;
        case (c)
            ADD:   e.res = a + b;
            SUB:   e.res = a - b;
            SLT:   begin cmp = 1'b1; cond = ($signed(a) < $signed(b)); end
            SLTU:  e.res = (a < b) ? 32'd1 : 32'd0;
            BLTU:  begin cmp = 1'b1; cond = (a < b); end
            BGE:   begin cmp = 1'b1; cond = !($signed(a) < $signed(b)); end
            BGEU:  begin cmp = 1'b1; cond = !(a < b); end
            EQ:    begin cmp = 1'b1; cond = (a == b); end
            NE:    begin cmp = 1'b1; cond = (a != b); end
            OR_:   e.res = a | b;
            XOR_:  e.res = a ^ b;
            AND_:  e.res = a & b;
            SLL:   e.res = a << b[4:0];
            SRL:   e.res = a >> b[4:0];
            SRA:   begin t = {{32{a[31]}}, a} >> b[4:0]; e.res = t[31:0]; end
            PASSA, PASSB: e.res = a;
            MUL:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); e.res = p[31:0];  e.lat = 33; end
            MULH:  begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); e.res = p[63:32]; e.lat = 33; end
            MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); e.res = p[63:32]; e.lat = 33; end
            MULHU: begin p = {32'b0, a} * {32'b0, b}; e.res = p[63:32]; e.lat = 33; end
`ifdef ALU_ITER_DIV_EN
            DIV, DIVU, REM, REMU: begin
                logic [31:0] q, r;
                e.lat = 33;
                if (b == 32'd0) begin
                    q = 32'hFFFFFFFF; r = a; e.lat = 1;
                end else if (!c[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    q = a; r = 32'd0; e.lat = 1;
                end else if (!c[0]) begin
                    q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
                end else begin
                    q = a / b; r = a % b;
                end
                e.res = c[1] ? r : q;
            end
`else
            DIV, DIVU, REM, REMU: e.res = 32'hFFFFFFFF;
`endif
            default: e.res = '0;
        endcase
        if (cmp) e.res = {31'b0, cond};
        e.br = bop & cmp & cond;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b, input logic bop);
        ALU_Control = c; operand_A = a; operand_B = b; branch_op = bop; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // lat = number of edges from accept until out_valid is seen; -1 if it never came
    task automatic wait_out(output int lat, output int bc);
        lat = 1; bc = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bc++;
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_txn(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic bop, output exp_t e, output int lat, output int bc);
        exp_q.push_back(model(c, a, b, bop));
        send(c, a, b, bop);
        wait_out(lat, bc);
        e = exp_q.pop_front();
        $display("txn ctrl=%b a=%h b=%h bop=%b -> res=%h br=%b lat=%0d busy=%0d",
                 c, a, b, bop, ALU_result, branch, lat, bc);
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (ALU_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", ALU_result); end
        checks++; if (branch !== 1'b0) begin errors++; $display("FAIL reset_branch: got %b want 0", branch); end
        reset_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_base();
        logic [5:0]  codes[18] = '{ADD, SUB, SLT, SLTU, BLTU, BGE, BGEU, OR_, XOR_, AND_, SLL, SRL, SRA, EQ, NE, PASSA, PASSB, UNL};
        logic [31:0] av[18] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFE, 32'd1, 32'd3, 32'h80000000, 32'h80000000,
                                32'hF0F0F0F0, 32'hFF00FF00, 32'h12345678, 32'd1, 32'h80000000, 32'h80000000,
                                32'h0000BEEF, 32'h0000BEEF, 32'hCAFEBABE, 32'h12345678, 32'hFFFFFFFF};
        logic [31:0] bv[18] = '{32'd1, 32'd7, 32'd1, 32'hFFFFFFFF, 32'd3, 32'h80000000, 32'h7FFFFFFF,
                                32'h0F0F0F0F, 32'h0FF00FF0, 32'h0F0F0F0F, 32'h00000025, 32'h0000003F,
                                32'h00000104, 32'h0000BEEF, 32'h0000BEEF, 32'd0, 32'd5, 32'd3};
        exp_t e; int lat; int bc;
        logic [5:0] c; logic [31:0] a, b; logic bop;
        for (int i = 0; i < 38; i++) begin
            if (i < 18) begin
                c = codes[i]; a = av[i]; b = bv[i]; bop = 1'b0;
            end else begin
                c = codes[$urandom_range(0, 17)]; a = $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                bop = 1'($urandom_range(0, 1));
            end
            do_txn(c, a, b, bop, e, lat, bc);
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL base_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
            checks++; if (ALU_result !== e.res) begin errors++; $display("FAIL base_result[%0d] ctrl=%b: got %h want %h", i, c, ALU_result, e.res); end
            checks++; if (branch !== e.br) begin errors++; $display("FAIL base_branch[%0d] ctrl=%b: got %b want %b", i, c, branch, e.br); end
            release_out();
        end
    endtask

    task automatic test_branch();
        logic [5:0]  codes[9] = '{BLTU, SLT, SLTU, EQ, NE, BGE, BGEU, ADD, EQ};
        logic [31:0] av[9] = '{32'd1, 32'd1, 32'd1, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd5};
        logic [31:0] bv[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5, 32'd1, 32'd1, 32'd2, 32'd5};
        logic        bops[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_t e; int lat; int bc;
        for (int i = 0; i < 9; i++) begin
            do_txn(codes[i], av[i], bv[i], bops[i], e, lat, bc);
            checks++; if (ALU_result !== e.res) begin errors++; $display("FAIL branch_result[%0d]: got %h want %h", i, ALU_result, e.res); end
            checks++; if (branch !== e.br) begin errors++; $display("FAIL branch_flag[%0d]: got %b want %b", i, branch, e.br); end
            release_out();
        end
    endtask

    task automatic test_mul();
        logic [5:0]  codes[6] = '{MULH, MULHU, MUL, MULHSU, MULH, MUL};
        logic [31:0] av[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        logic [31:0] bv[6] = '{32'd2, 32'd2, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'h80000000, 32'd5};
        exp_t e; int lat; int bc;
        logic [5:0] c; logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                c = codes[i]; a = av[i]; b = bv[i];
            end else begin
                c = {4'b1000, 2'($urandom_range(0, 3))}; a = $urandom; b = $urandom;
            end
            do_txn(c, a, b, 1'b1, e, lat, bc);
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
            checks++; if (bc !== e.lat - 1) begin errors++; $display("FAIL mul_busy_cycles[%0d]: got %0d want %0d", i, bc, e.lat - 1); end
            checks++; if (ALU_result !== e.res) begin errors++; $display("FAIL mul_result[%0d] ctrl=%b: got %h want %h", i, c, ALU_result, e.res); end
            checks++; if (branch !== 1'b0) begin errors++; $display("FAIL mul_branch[%0d]: got %b want 0", i, branch); end
            release_out();
        end
    endtask

    task automatic test_div();
        logic [5:0]  codes[8] = '{DIV, REM, DIVU, DIV, REMU, REM, DIV, REMU};
        logic [31:0] av[8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100, 32'h80000000, 32'h80000000, 32'd5};
        logic [31:0] bv[8] = '{32'd2, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, 32'd2, 32'd0};
        exp_t e; int lat; int bc;
        logic [5:0] c; logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                c = codes[i]; a = av[i]; b = bv[i];
            end else begin
                c = {4'b1001, 2'($urandom_range(0, 3))}; a = $urandom; b = $urandom >> $urandom_range(0, 28);
            end
            do_txn(c, a, b, 1'b1, e, lat, bc);
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
            checks++; if (bc !== e.lat - 1) begin errors++; $display("FAIL div_busy_cycles[%0d]: got %0d want %0d", i, bc, e.lat - 1); end
            checks++; if (ALU_result !== e.res) begin errors++; $display("FAIL div_result[%0d] ctrl=%b: got %h want %h", i, c, ALU_result, e.res); end
            checks++; if (branch !== 1'b0) begin errors++; $display("FAIL div_branch[%0d]: got %b want 0", i, branch); end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        exp_t e; int lat; int bc;
        do_txn(XOR_, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, e, lat, bc);
        checks++; if (ALU_result !== e.res) begin errors++; $display("FAIL bp_result: got %h want %h", ALU_result, e.res); end
        ALU_Control = MUL; operand_A = 32'd3; operand_B = 32'd4; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (ALU_result !== e.res) begin errors++; $display("FAIL bp_hold_result[%0d]: got %h want %h", i, ALU_result, e.res); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_accept_on_handshake: busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_flush();
        exp_t e; int lat; int bc; int ov; int bz;
        send(MUL, 32'h1234, 32'h5678, 1'b0);
        repeat (9) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
        flush = 1'b1; in_valid = 1'b1; ALU_Control = ADD;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        ALU_Control = MUL;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        ov = 0; bz = 0;
        repeat (40) begin
            if (out_valid) ov++;
            if (busy) bz++;
            tick();
        end
        checks++; if (ov !== 0) begin errors++; $display("FAIL flush_out_valid_cycles: got %0d want 0", ov); end
        checks++; if (bz !== 0) begin errors++; $display("FAIL flush_accepted_busy_cycles: got %0d want 0", bz); end
        send(ADD, 32'd1, 32'd2, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_done_valid: got %b want 0", out_valid); end
        do_txn(SUB, 32'd10, 32'd3, 1'b0, e, lat, bc);
        checks++; if (ALU_result !== e.res) begin errors++; $display("FAIL flush_recover_result: got %h want %h", ALU_result, e.res); end
        release_out();
    endtask

    task automatic test_reset_midop();
        int ov; int bz;
        send(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        repeat (9) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (ALU_result !== 32'd0) begin errors++; $display("FAIL rst_result: got %h want 0", ALU_result); end
        tick();
        reset_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        ov = 0; bz = 0;
        repeat (40) begin
            if (out_valid) ov++;
            if (busy) bz++;
            tick();
        end
        checks++; if (ov !== 0) begin errors++; $display("FAIL rst_out_valid_cycles: got %0d want 0", ov); end
        checks++; if (bz !== 0) begin errors++; $display("FAIL rst_busy_cycles: got %0d want 0", bz); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  codes[5] = '{ADD, MUL, SUB, DIVU, MULHSU};
        logic [31:0] av[5] = '{32'd40, 32'hFFFFFFFD, 32'd9, 32'd1000, 32'h80000001};
        logic [31:0] bv[5] = '{32'd2, 32'd7, 32'd12, 32'd9, 32'd3};
        exp_t e; int lat; int bc;
        for (int i = 0; i < 5; i++) begin
            do_txn(codes[i], av[i], bv[i], 1'b0, e, lat, bc);
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
            checks++; if (ALU_result !== e.res) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, ALU_result, e.res); end
            release_out();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
        end
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; branch_op = 1'b0;
        ALU_Control = '0; operand_A = '0; operand_B = '0;
        test_reset();
        test_base();
        test_branch();
        test_mul();
        test_div();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset is asynchronous and active-low.
REQ-005 flush  in  1  abort any accepted or in-flight operation.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 branch_op  in  1  request is a conditional branch.
REQ-009 ALU_Control  in  6  operation code.
REQ-010 operand_A  in  XLEN  first operand.
REQ-011 operand_B  in  XLEN  second operand.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer takes result.
REQ-014 ALU_result  out  XLEN  registered result.
REQ-015 branch  out  1  registered branch-taken flag.
REQ-016 busy  out  1  high in BUSY state.

Function
REQ-017 Base codes SHALL be: 000000 add; 001000 sub; 000010 signed-lt (SLT/BLT); 000011 and 010110 unsigned-lt; 010101 signed-ge; 010111 unsigned-ge; 000110 or; 000100 xor; 000111 and; 000001 sll; 000101 srl; 001101 sra; 010000 eq; 010001 ne; 011111 and 111111 pass operand_A.
REQ-018 M-extension codes SHALL be: 100000 MUL; 100001 MULH; 100010 MULHSU; 100011 MULHU; 100100 DIV; 100101 DIVU; 100110 REM; 100111 REMU.
REQ-019 Unlisted codes SHALL complete as base ops with ALU_result 0 and branch 0.
REQ-020 Compare ops SHALL return zero-extended 1/0 in ALU_result.
REQ-021 Shifts SHALL use only operand_B[SHW-1:0]; sra SHALL replicate operand_A MSB.
REQ-022 branch SHALL be 1 only when branch_op=1 and the code is a compare (eq, ne, signed-lt, 010110, signed-ge, unsigned-ge) whose condition holds; else 0.
REQ-023 FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE) && !flush.
REQ-024 Accept occurs when in_valid && in_ready; operands and code SHALL be captured that edge.
REQ-025 Base op: IDLE->DONE on accept; out_valid high the next cycle (latency 1).
REQ-026 Multiply: IDLE->BUSY; radix-2 shift-add over 2*XLEN product, exactly XLEN BUSY cycles, then DONE; MUL low half, MULH/MULHSU/MULHU high half with signed/signed, signed/unsigned, unsigned/unsigned operands.
REQ-027 Divide: restoring, exactly XLEN BUSY cycles, then DONE; signed ops on magnitudes with quotient sign = sign(A) xor sign(B), remainder sign = sign(A).
REQ-028 Divide by zero SHALL skip BUSY (latency 1): quotient all-ones, remainder = operand_A.
REQ-029 Signed overflow (A = most-negative, B = -1) SHALL skip BUSY: quotient = A, remainder 0.
REQ-030 DONE: out_valid=1, ALU_result/branch stable until out_ready=1; then DONE->IDLE, out_valid=0 next cycle.
REQ-031 No new request SHALL be accepted in the cycle the result handshakes (one op in flight max).
REQ-032 flush in any state SHALL force IDLE next edge, out_valid 0, result discarded; flush with in_valid accepts nothing.
REQ-033 Inputs SHALL be ignored while not IDLE.

Reset
REQ-034 reset_n low SHALL immediately force IDLE, out_valid 0, busy 0, ALU_result 0, branch 0, iteration counter 0.
REQ-035 Reset mid-multiply/divide SHALL abandon the op; no result appears after release.
REQ-036 in_ready SHALL be 1 first cycle after reset_n release (flush low).

Configuration
REQ-037 Macro ALU_ITER_DIV_EN: defined -> divider built, REQ-027..029 apply.
REQ-038 Undefined -> no divider logic; codes 100100-100111 complete in 1 cycle with ALU_result all-ones, branch 0; multiply unaffected.

Verification
REQ-039 XLEN=32, add 0x7FFFFFFF+1 -> out_valid one cycle after accept, ALU_result 0x80000000.
REQ-040 MULH A=0xFFFFFFFF(-1) B=0x00000002 -> 32 BUSY cycles, ALU_result 0xFFFFFFFF; MULHU same operands -> 0x00000001.
REQ-041 DIV A=-7 B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU A=7 B=0 -> 0xFFFFFFFF at latency 1; DIV 0x80000000/-1 -> 0x80000000.
REQ-042 branch_op=1, code 010110, A=1 B=0xFFFFFFFF -> branch 1, ALU_result 1; code 000010 same operands -> branch 0.
REQ-043 Hold out_ready=0 for 5 cycles after DONE -> result/out_valid stable, in_ready 0; then handshake, IDLE next cycle.
REQ-044 flush at BUSY cycle 10 of MUL, and reset_n low at cycle 10 in a second run -> IDLE, out_valid never asserts for that op; build without ALU_ITER_DIV_EN: DIV -> 0xFFFFFFFF at latency 1.
